// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: buffers host read/write commands in a small FIFO and
// issues them one at a time to the APB master's system interface. Each
// command produces exactly one response (data or error) on a valid/ready port.
module apb_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int WD_LIMIT  = 64
) (
    input  logic                       apb_clk,
    input  logic                       sys_reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [7:0]                 cmd_addr,
    input  logic [31:0]                cmd_wdata,
    input  logic                       cmd_write,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic                       rsp_write,
    output logic [$clog2(CMD_DEPTH):0] cmd_level,
    output logic [7:0]                 err_count,
    output logic                       busy,
    output logic [7:0]                 m_addr,
    output logic [31:0]                m_data,
    output logic                       m_data_dir,
    output logic                       m_data_valid,
    input  logic [31:0]                m_read_out_data,
    input  logic                       m_transaction_done,
    input  logic                       m_tranerr
);

    localparam int AW  = $clog2(CMD_DEPTH);
    localparam int WDW = $clog2(WD_LIMIT + 1);
    localparam logic [AW:0]    LEVEL_FULL = (AW + 1)'(CMD_DEPTH);
    localparam logic [WDW-1:0] WD_LAST    = WDW'(WD_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]  r_fifo_addr  [CMD_DEPTH];
    logic [31:0] r_fifo_wdata [CMD_DEPTH];
    logic        r_fifo_write [CMD_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    logic [7:0]  r_m_addr;
    logic [31:0] r_m_data;
    logic        r_m_dir;

    logic [WDW-1:0] r_wd;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_rsp_write;
    logic [7:0]  r_err_count;

    logic w_push;
    logic w_pop;
    logic w_exit;
    logic w_fifo_empty;

    assign w_fifo_empty = (r_level == '0);
    assign cmd_ready    = (r_level != LEVEL_FULL);
    assign w_push       = cmd_valid && cmd_ready;

    // Next-state and pop/exit decode; done outranks tranerr, which outranks the watchdog.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_exit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (m_transaction_done || m_tranerr || (r_wd == WD_LAST)) begin
                    w_exit = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count, so no reset.
    always_ff @(posedge apb_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= cmd_addr;
            r_fifo_wdata[r_wr_ptr] <= cmd_wdata;
            r_fifo_write[r_wr_ptr] <= cmd_write;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Master holding registers, loaded on pop and stable until the next pop.
    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_m_addr <= '0;
            r_m_data <= '0;
            r_m_dir  <= 1'b0;
        end else if (w_pop) begin
            r_m_addr <= r_fifo_addr[r_rd_ptr];
            r_m_data <= r_fifo_write[r_rd_ptr] ? r_fifo_wdata[r_rd_ptr] : 32'd0;
            r_m_dir  <= r_fifo_write[r_rd_ptr];
        end
    end

    // Watchdog counts WAIT cycles; it sits at zero in every other state.
    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_wd <= '0;
        end else if (r_state == S_WAIT) begin
            r_wd <= r_wd + 1'b1;
        end else begin
            r_wd <= '0;
        end
    end

    // Response capture on WAIT exit; held until the host handshake.
    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_write <= 1'b0;
        end else if (w_exit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_m_dir;
            if (m_transaction_done) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= r_m_dir ? 32'd0 : m_read_out_data;
            end else begin
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= 32'd0;
            end
        end else if ((r_state == S_RESP) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Saturating count of error exits (master error or watchdog).
    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_err_count <= '0;
        end else if (w_exit && !m_transaction_done && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign m_data_valid = (r_state == S_ISSUE);
    assign m_addr       = r_m_addr;
    assign m_data       = r_m_data;
    assign m_data_dir   = r_m_dir;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign rsp_write    = r_rsp_write;
    assign cmd_level    = r_level;
    assign err_count    = r_err_count;
    assign busy         = (r_state != S_IDLE) || !w_fifo_empty;

endmodule

// File: doc/apb_cmd_sequencer.md
# apb_cmd_sequencer

Command front-end for the APB master. Accepts read/write commands from a host over a valid/ready port, buffers them in a small FIFO, and issues them one at a time to the master's system interface. Each command waits for the master's completion or error. Every command produces exactly one response (read data or error flag) on a valid/ready response port.

## Interface
Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of two, 2..16.
- WD_LIMIT, 64: watchdog cycles in WAIT before a forced error response; must exceed master timeout_limit + 4.

Ports:
- apb_clk  in  1  clock; all logic on rising edge.
- sys_reset  in  1  reset, asynchronous, active-low. The top level drives the master's apb_reset with ~sys_reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO not full; combinational.
- cmd_addr  in  8  target address.
- cmd_wdata  in  32  write data; ignored for reads.
- cmd_write  in  1  1 = write, 0 = read.
- rsp_valid  out  1  response valid; registered.
- rsp_ready  in  1  host accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  transaction ended by master timeout or watchdog.
- rsp_write  out  1  echo of the command's cmd_write.
- cmd_level  out  log2(CMD_DEPTH)+1  FIFO occupancy.
- err_count  out  8  saturating error counter.
- busy  out  1  state != IDLE or FIFO non-empty.
- m_addr  out  8  to master addr.
- m_data  out  32  to master data.
- m_data_dir  out  1  to master data_dir.
- m_data_valid  out  1  to master data_valid; single-cycle pulse.
- m_read_out_data  in  32  from master read_out_data.
- m_transaction_done  in  1  from master transaction_done.
- m_tranerr  in  1  from master apb_tranerr; combinational in master.

## Operation
Command FIFO:
- Push on cmd_valid && cmd_ready.
- Pop only in IDLE when non-empty.
- Push and pop on the same edge leave cmd_level unchanged.
- Pointers wrap modulo CMD_DEPTH.
- cmd_ready = (cmd_level != CMD_DEPTH), so a push while full cannot occur.

State machine (IDLE, ISSUE, WAIT, RESP):
- IDLE: if the FIFO is non-empty, pop the head into the m_addr/m_data/m_data_dir holding registers and go to ISSUE.
  - m_data is forced to 0 for reads.
- ISSUE: m_data_valid = 1 for this single cycle, then go to WAIT unconditionally.
  - The holding registers stay stable from ISSUE until the edge that leaves WAIT.
- WAIT: watchdog counter increments each cycle; it is cleared on entry. Exit priority:
  1. m_transaction_done = 1: capture rsp_rdata = m_read_out_data for reads (0 for writes), rsp_err = 0.
  2. m_tranerr = 1: rsp_err = 1, rsp_rdata = 0.
  3. Watchdog == WD_LIMIT-1: rsp_err = 1, rsp_rdata = 0.
  - Any exit sets rsp_valid and goes to RESP.
  - Exits 2 and 3 increment err_count, saturating at 255.
- RESP: hold rsp_* stable. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
- No new command issues while a response is pending; responses are in command order.

## Timing
- Reset values: rsp_valid 0, rsp_rdata 0, rsp_err 0, rsp_write 0, m_data_valid 0, m_addr 0, m_data 0, m_data_dir 0, err_count 0, cmd_level 0, busy 0, state IDLE, FIFO empty. cmd_ready is 1 while in reset.
- Issue latency, command accepted at edge N into an empty FIFO while IDLE:
  - FIFO non-empty during cycle N.
  - Pop at edge N+1; m_data_valid high during cycle N+1 only.
  - Master enters SETUP at edge N+2.
- Completion latency: rsp_valid rises on the edge after the cycle in which m_transaction_done or m_tranerr is seen high.
- Turnaround: one IDLE bubble after each response handshake. With zero slave wait and rsp_ready tied high, throughput is one command per 7 cycles.
- m_data_valid is never high outside ISSUE, so the master cannot re-launch a command when it returns to IDLE before done is seen.
- Reset mid-operation: asynchronous clear of all state. An in-flight command and queued commands are discarded with no response.
- m_transaction_done or m_tranerr outside WAIT: ignored.

## Test plan
- Write then read back: push write addr 4 data 10, then read addr 4 (slave wait_cycle 0), rsp_ready = 1 -> responses (write, err 0, rdata 0), then (read, err 0, rdata 10); m_data_valid pulses exactly twice, 1 cycle each.
- FIFO full: hold rsp_ready = 0 and push 6 writes with CMD_DEPTH 4 -> cmd_ready drops after the 5th push (4 queued, 1 in flight); cmd_level = 4; release rsp_ready -> 5 responses then the 6th, in order, addresses preserved.
- Master timeout: slave never asserts ready, master timeout_limit 20 -> one response with rsp_err 1, rdata 0; err_count = 1; next queued command completes normally.
- Watchdog: tie m_transaction_done and m_tranerr to 0 -> rsp_err 1 exactly WD_LIMIT cycles after WAIT entry; err_count saturates at 255 after 300 such commands.
- Backpressure: read completes while rsp_ready = 0 for 10 cycles -> rsp_rdata and rsp_err stable throughout, no new m_data_valid until the handshake.
- Async reset asserted in WAIT with 2 commands queued -> all outputs at reset values immediately, no response after release, cmd_level = 0.
